ddr_burst_deser: RTL
====================

# ddr_burst_deser

Parametrised multi-lane DDR burst deserialiser that sits behind the DQ capture cells on the read return path. It accepts one rise-phase bit and one fall-phase bit per lane per clock, collects a full burst (BL_MAX beats) or a chopped burst (BL_MAX/2 beats), and presents the assembled burst word with a one-cycle valid strobe. It supports seamless back-to-back bursts and flags protocol errors instead of corrupting data.

## Interface
- LANES, 8: number of DQ lanes (≥1).
- BL_MAX, 16: full burst length in beats (even, ≥4).
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  the current cycle carries beats 0/1 of a new burst.
- chop_i  in  1  sampled only with an accepted start_i; 1 selects a burst of BL_MAX/2 beats.
- rise_i  in  LANES  even beat for each lane this cycle.
- fall_i  in  LANES  odd beat for each lane this cycle.
- data_o  out  LANES*BL_MAX  assembled burst; beat b, lane l is at bit b*LANES+l.
- valid_o  out  1  one-cycle strobe marking data_o as new.
- chop_o  out  1  chop flag of the burst currently on data_o.
- busy_o  out  1  a burst is being collected.
- err_o  out  1  one-cycle pulse: start_i was rejected.

## Operation
- States: IDLE and CAPTURE. Beat-pair counter width is $clog2(BL_MAX/2)+1. Target pair count is BL_MAX/2, or BL_MAX/4 when chopped.
- Accepting start: start_i is accepted in IDLE, or on the cycle right after the last pair of the previous burst. Acceptance latches chop_i, writes rise_i/fall_i into beats 0/1 of the collection buffer, clears all higher beats, and sets count=1.
- Collecting: in CAPTURE, each cycle writes beat pair (2k, 2k+1), where k is the current count, then increments the count.
- Completion: when the count reaches the target, the buffer is transferred to data_o. chop_o is updated and valid_o pulses on the next cycle. The FSM returns to IDLE unless a new start is accepted on that same cycle.
- Chopped bursts: beats BL_MAX/2 through BL_MAX-1 of data_o are zero.
- Single-cycle bursts: with BL_MAX=4 and chop, the burst completes in the start cycle itself; there is no CAPTURE cycle.
- Rejected start: start_i in CAPTURE before the final pair is ignored (this includes the final-pair cycle). err_o pulses on the next cycle, and the current burst continues and completes with unaltered data.
- Hold: data_o and chop_o hold between valid_o strobes.
- busy_o is 1 exactly while in CAPTURE.
- Reset: rst_i at any time aborts a burst in progress; no valid_o is issued for it.
- Reset values: data_o=0, valid_o=0, chop_o=0, busy_o=0, err_o=0, state IDLE, counter 0.

## Timing
- Start at cycle 0: the last pair is presented at cycle BL_MAX/2-1 (full) or BL_MAX/4-1 (chop).
- valid_o is high at cycle BL_MAX/2 (full) or BL_MAX/4 (chop). Latency is one cycle after the last pair.
- Back-to-back: a start presented in the valid_o cycle is accepted, so streaming bursts have zero gap.
- err_o has one-cycle latency after the rejected start_i.
- After rst_i deasserts, start_i is accepted on the first cycle with rst_i=0.
- No combinational path from any input to any output.

## Structure
- Shared package ddr_deser_pkg holds:
  - the state enum (IDLE, CAPTURE);
  - a beat/lane bit-index function (b*LANES+l);
  - a localparam function computing the pair-count target from BL_MAX and the chop flag.
- No sub-module. The collection buffer is a single LANES*BL_MAX register written per beat pair, with an indexed part-select.

## Test plan
- Reset: drive rst_i for 2 cycles mid-traffic → all outputs 0 and busy_o=0 on the cycle after rst_i is sampled high.
- Full burst (LANES=8, BL_MAX=16): start at cycle 0; rise_i=2k and fall_i=2k+1 on cycles k=0..7 → valid_o only at cycle 8, data_o byte b = b for b=0..15, chop_o=0.
- Chopped burst: start with chop_i=1; same pattern on cycles 0..3 → valid_o at cycle 4, bytes 0..7 = b, bytes 8..15 = 0, chop_o=1.
- Back-to-back: full bursts starting at cycles 0 and 8 → valid_o at cycles 8 and 16, busy_o continuously 1 from cycle 1 through 15, err_o never asserted.
- Rejected start: extra start_i at cycle 3 (and again at cycle 7) of a full burst → err_o at cycles 4 and 8, valid_o at cycle 8 with unchanged first-burst data, no second valid_o.
- Reset mid-burst: rst_i at cycle 5 → no valid_o, busy_o=0 at cycle 6. A new start at cycle 6 completes normally with valid_o at cycle 14.

Source files
------------

// File: rtl/ddr_deser_pkg.sv
// Shared types and helpers for the DDR burst deserialiser.
// Beat/lane indexing and burst pair targets live here.
package ddr_deser_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  function automatic int bit_idx(
    input int b,
    input int l,
    input int lanes
  );
    return b * lanes + l;
  endfunction

  function automatic int pair_target(
    input int   bl_max,
    input logic chop
  );
    return chop ? bl_max / 4 : bl_max / 2;
  endfunction

endpackage

// File: rtl/ddr_burst_deser.sv
// Multi-lane DDR burst deserialiser for the read return path.
// Collects rise/fall beat pairs into a burst word with a valid strobe.
module ddr_burst_deser
  import ddr_deser_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int BL_MAX = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    chop_i,
  input  logic [LANES-1:0]        rise_i,
  input  logic [LANES-1:0]        fall_i,
  output logic [LANES*BL_MAX-1:0] data_o,
  output logic                    valid_o,
  output logic                    chop_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int DW = LANES * BL_MAX;
  localparam int PW = 2 * LANES;
  localparam int CW = $clog2(BL_MAX / 2) + 1;

  localparam logic [CW-1:0] TGT_FULL =
    CW'(pair_target(BL_MAX, 1'b0));
  localparam logic [CW-1:0] TGT_CHOP =
    CW'(pair_target(BL_MAX, 1'b1));
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   tgt_q;
  logic [CW-1:0]   tgt_in;
  logic            chop_q;
  logic            chop_d;
  logic [DW-1:0]   buf_q;
  logic [DW-1:0]   buf_d;
  logic [PW-1:0]   pair;
  logic            open_w;
  logic            accept;
  logic            collect;
  logic            reject;
  logic            done;

  assign pair   = {fall_i, rise_i};
  assign tgt_q  = chop_q ? TGT_CHOP : TGT_FULL;
  assign tgt_in = chop_i ? TGT_CHOP : TGT_FULL;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CAPTURE with cnt==target is the hand-off cycle
  // that lets the next burst start with no gap.
  always_comb begin
    open_w  = (state_q == IDLE) ||
              (cnt_q == tgt_q);
    accept  = start_i && open_w;
    collect = (state_q == CAPTURE) &&
              (cnt_q < tgt_q);
    reject  = start_i && collect;
    done    = (accept && tgt_in == ONE) ||
              (collect && (cnt_q + ONE) == tgt_q);
    state_d = IDLE;
    unique case (1'b1)
      accept:  state_d = (tgt_in == ONE) ? IDLE
                                         : CAPTURE;
      collect: state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    chop_d = chop_q;
    buf_d  = buf_q;
    unique case (1'b1)
      accept: begin
        cnt_d         = ONE;
        chop_d        = chop_i;
        buf_d         = '0;
        buf_d[PW-1:0] = pair;
      end
      collect: begin
        cnt_d = cnt_q + ONE;
        buf_d[bit_idx(2 * int'(cnt_q), 0, LANES) +: PW]
              = pair;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      chop_q  <= 1'b0;
      buf_q   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      chop_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      chop_q  <= chop_d;
      buf_q   <= buf_d;
      valid_o <= done;
      err_o   <= reject;
      if (done) begin
        data_o <= buf_d;
        chop_o <= chop_d;
      end
    end
  end

  always_comb begin
    busy_o = (state_q == CAPTURE);
  end

endmodule
